// File: rtl/kgp_dmem_ctrl_if.sv
// kgp_dmem_ctrl_if: request/response bus between the load/store stage and the data-memory controller
interface kgp_dmem_ctrl_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/kgp_dmem_ctrl.sv
// kgp_dmem_ctrl: byte-lane data memory with sized/extended loads, error checks and 1/2-cycle read latency
module kgp_dmem_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 1
) (
  input logic            clka,
  input logic            rst_n,
  kgp_dmem_ctrl_if.slave bus
);
  typedef enum logic {IDLE, RD_WAIT} state_t;
  state_t                state;
  logic [31:0]           mem [2**DEPTH_LOG2];
  logic [1:0]            a;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  acc, err, go_wait, rdy;
  logic [3:0]            be;
  logic [31:0]           wd, rd_word, rdata_c;
  logic [15:0]           sh;
  logic                  p_valid, p_ld, p_err, p_sg;
  logic [1:0]            p_sz, p_lane;
  assign a       = bus.req_addr[1:0];
  assign idx     = bus.req_addr[DEPTH_LOG2+1:2];
  assign acc     = bus.req_valid && rdy;
  assign err     = bus.req_size == 2'd3 || (bus.req_size == 2'd1 && a[0]) ||
                   (bus.req_size == 2'd2 && a != 2'd0) || |bus.req_addr[ADDR_W-1:DEPTH_LOG2+2];
  assign go_wait = RD_LAT == 2 && acc && !bus.req_we && !err;
  assign be      = bus.req_size == 2'd0 ? 4'b0001 << a : bus.req_size == 2'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // replicate store data so every enabled lane sees its right-aligned bytes
  assign wd      = bus.req_size == 2'd0 ? {4{bus.req_wdata[7:0]}} :
                   bus.req_size == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  assign bus.req_ready = rdy;
  always_ff @(posedge clka) begin
    for (int i = 0; i < 4; i++)
      if (acc && bus.req_we && !err && be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    if (acc && !bus.req_we) rd_word <= mem[idx];
  end
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      rdy     <= 1'b0;
      p_valid <= 1'b0;
      p_ld    <= 1'b0;
      p_err   <= 1'b0;
      p_sg    <= 1'b0;
      p_sz    <= 2'd0;
      p_lane  <= 2'd0;
    end else begin
      state   <= state == IDLE && go_wait ? RD_WAIT : IDLE;
      rdy     <= !(state == IDLE && go_wait);
      p_valid <= acc;
      if (acc) begin
        p_ld   <= !bus.req_we && !err;
        p_err  <= err;
        p_sg   <= bus.req_signed;
        p_sz   <= bus.req_size;
        p_lane <= a;
      end
    end
  assign sh      = 16'(rd_word >> {p_lane, 3'b000});
  assign rdata_c = !p_ld ? 32'd0 :
                   p_sz == 2'd0 ? {{24{p_sg && sh[7]}}, sh[7:0]} :
                   p_sz == 2'd1 ? {{16{p_sg && sh[15]}}, sh} : rd_word;
  if (RD_LAT == 2) begin : g_lat2
    logic        o_valid, o_err;
    logic [31:0] o_rdata;
    always_ff @(posedge clka or negedge rst_n)
      if (!rst_n) begin
        o_valid <= 1'b0;
        o_err   <= 1'b0;
        o_rdata <= 32'd0;
      end else begin
        o_valid <= p_valid;
        if (p_valid) begin
          o_rdata <= rdata_c;
          o_err   <= p_err;
        end
      end
    assign bus.rsp_valid = o_valid;
    assign bus.rsp_rdata = o_rdata;
    assign bus.rsp_err   = o_err;
  end else begin : g_lat1
    assign bus.rsp_valid = p_valid;
    assign bus.rsp_rdata = rdata_c;
    assign bus.rsp_err   = p_err;
  end
endmodule

// File: tb/tb_kgp_dmem_ctrl.sv
// tb_kgp_dmem_ctrl: directed checks of the data-memory controller at read latency 1 and 2
module tb_kgp_dmem_ctrl;
  logic clka = 1'b0, rst_n = 1'b0;
  logic v1 = 1'b0, v2 = 1'b0, t_we = 1'b0, t_sg = 1'b0;
  logic [1:0] t_sz = 2'd0;
  logic [31:0] t_a = 32'd0, t_wd = 32'd0;
  int n_chk = 0, n_fail = 0;
  always #5 clka = ~clka;
  kgp_dmem_ctrl_if #(.ADDR_W(32)) b1 ();
  kgp_dmem_ctrl_if #(.ADDR_W(32)) b2 ();
  assign b1.req_valid = v1;
  assign b1.req_we = t_we;
  assign b1.req_size = t_sz;
  assign b1.req_signed = t_sg;
  assign b1.req_addr = t_a;
  assign b1.req_wdata = t_wd;
  assign b2.req_valid = v2;
  assign b2.req_we = t_we;
  assign b2.req_size = t_sz;
  assign b2.req_signed = t_sg;
  assign b2.req_addr = t_a;
  assign b2.req_wdata = t_wd;
  kgp_dmem_ctrl #(.ADDR_W(32), .DEPTH_LOG2(10), .RD_LAT(1)) u1 (.clka(clka), .rst_n(rst_n), .bus(b1));
  kgp_dmem_ctrl #(.ADDR_W(32), .DEPTH_LOG2(10), .RD_LAT(2)) u2 (.clka(clka), .rst_n(rst_n), .bus(b2));

  function automatic logic rdy(input int lat); return lat == 1 ? b1.req_ready : b2.req_ready; endfunction
  function automatic logic rv(input int lat); return lat == 1 ? b1.rsp_valid : b2.rsp_valid; endfunction
  function automatic logic [31:0] rrd(input int lat); return lat == 1 ? b1.rsp_rdata : b2.rsp_rdata; endfunction
  function automatic logic rer(input int lat); return lat == 1 ? b1.rsp_err : b2.rsp_err; endfunction
  task automatic set_v(input int lat, input logic v);
    if (lat == 1) v1 = v; else v2 = v;
  endtask

  // one request on the selected controller; lt = negedges from accept to response (99 = none)
  task automatic xfer(input int lat, input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lt);
    int n;
    n = 0;
    @(negedge clka);
    while (!rdy(lat) && n < 10) begin @(negedge clka); n++; end
    t_we = we; t_sz = sz; t_sg = sg; t_a = a; t_wd = wd;
    set_v(lat, 1'b1);
    @(posedge clka);
    #1 set_v(lat, 1'b0);
    lt = 0;
    do begin @(negedge clka); lt++; end while (!rv(lat) && lt < 8);
    if (!rv(lat)) lt = 99;
    rd = rrd(lat);
    er = rer(lat);
  endtask

  task automatic test_reset;
    int pulses;
    @(negedge clka);
    if (b1.req_ready !== 1'b0 || b1.rsp_valid !== 1'b0 || b1.rsp_rdata !== 32'd0 || b1.rsp_err !== 1'b0) begin
      $display("FAIL reset_l1 got rdy=%b v=%b d=%h e=%b exp 0/0/0/0", b1.req_ready, b1.rsp_valid, b1.rsp_rdata, b1.rsp_err); n_fail++; end
    n_chk++;
    if (b2.req_ready !== 1'b0 || b2.rsp_valid !== 1'b0 || b2.rsp_rdata !== 32'd0 || b2.rsp_err !== 1'b0) begin
      $display("FAIL reset_l2 got rdy=%b v=%b d=%h e=%b exp 0/0/0/0", b2.req_ready, b2.rsp_valid, b2.rsp_rdata, b2.rsp_err); n_fail++; end
    n_chk++;
    rst_n = 1'b1;
    @(posedge clka);
    @(negedge clka);
    if (b1.req_ready !== 1'b1 || b2.req_ready !== 1'b1) begin
      $display("FAIL ready_after_reset got %b%b exp 11", b1.req_ready, b2.req_ready); n_fail++; end
    n_chk++;
    t_we = 1'b0; t_sz = 2'd2; t_a = 32'h0; v1 = 1'b1; v2 = 1'b1;
    @(posedge clka);
    #1 v1 = 1'b0; v2 = 1'b0;
    #1 rst_n = 1'b0;
    pulses = 0;
    repeat (2) begin @(negedge clka); pulses += int'(b1.rsp_valid) + int'(b2.rsp_valid); end
    if (b1.req_ready !== 1'b0 || b2.req_ready !== 1'b0) begin
      $display("FAIL ready_in_reset got %b%b exp 00", b1.req_ready, b2.req_ready); n_fail++; end
    n_chk++;
    rst_n = 1'b1;
    @(posedge clka);
    @(negedge clka);
    if (b1.req_ready !== 1'b1 || b2.req_ready !== 1'b1) begin
      $display("FAIL ready_after_midread got %b%b exp 11", b1.req_ready, b2.req_ready); n_fail++; end
    n_chk++;
    pulses += int'(b1.rsp_valid) + int'(b2.rsp_valid);
    repeat (3) begin @(negedge clka); pulses += int'(b1.rsp_valid) + int'(b2.rsp_valid); end
    if (pulses !== 0) begin $display("FAIL discarded_read got pulses=%0d exp 0", pulses); n_fail++; end
    n_chk++;
  endtask

  task automatic test_word(input int lat);
    logic [31:0] rd; logic er; int lt;
    xfer(lat, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lt);
    if (rd !== 32'd0 || er !== 1'b0) begin $display("FAIL store_rsp lat=%0d got d=%h e=%b exp 0/0", lat, rd, er); n_fail++; end
    n_chk++;
    xfer(lat, 1'b0, 2'd2, 1'b1, 32'h10, 32'h0, rd, er, lt);
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin $display("FAIL word_load lat=%0d got d=%h e=%b exp deadbeef/0", lat, rd, er); n_fail++; end
    n_chk++;
    if (lt !== lat) begin $display("FAIL load_latency lat=%0d got %0d exp %0d", lat, lt, lat); n_fail++; end
    n_chk++;
  endtask

  task automatic test_byte(input int lat);
    logic [31:0] rd; logic er; int lt;
    xfer(lat, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, rd, er, lt);
    xfer(lat, 1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFF80, rd, er, lt);
    xfer(lat, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lt);
    if (rd !== 32'h80223344) begin $display("FAIL byte_merge lat=%0d got %h exp 80223344", lat, rd); n_fail++; end
    n_chk++;
    xfer(lat, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er, lt);
    if (rd !== 32'hFFFFFF80) begin $display("FAIL lb_signed lat=%0d got %h exp ffffff80", lat, rd); n_fail++; end
    n_chk++;
    xfer(lat, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er, lt);
    if (rd !== 32'h00000080) begin $display("FAIL lb_unsigned lat=%0d got %h exp 00000080", lat, rd); n_fail++; end
    n_chk++;
    xfer(lat, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, er, lt);
    if (rd !== 32'hFFFF8022) begin $display("FAIL lh_signed lat=%0d got %h exp ffff8022", lat, rd); n_fail++; end
    n_chk++;
    xfer(lat, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, rd, er, lt);
    if (rd !== 32'h00000033) begin $display("FAIL lb_pos lat=%0d got %h exp 00000033", lat, rd); n_fail++; end
    n_chk++;
    xfer(lat, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, rd, er, lt);
    xfer(lat, 1'b0, 2'd2, 1'b1, 32'h10, 32'h0, rd, er, lt);
    if (rd !== 32'hBEEF3344) begin $display("FAIL half_merge lat=%0d got %h exp beef3344", lat, rd); n_fail++; end
    n_chk++;
  endtask

  task automatic test_errors(input int lat);
    logic [31:0] rd; logic er; int lt;
    xfer(lat, 1'b1, 2'd2, 1'b0, 32'h0, 32'hA5A5A5A5, rd, er, lt);
    xfer(lat, 1'b1, 2'd2, 1'b0, 32'h4, 32'h5A5A5A5A, rd, er, lt);
    xfer(lat, 1'b0, 2'd2, 1'b0, 32'h2, 32'h0, rd, er, lt);
    if (er !== 1'b1 || rd !== 32'd0 || lt !== lat) begin
      $display("FAIL err_word_misalign lat=%0d got e=%b d=%h lt=%0d exp 1/0/%0d", lat, er, rd, lt, lat); n_fail++; end
    n_chk++;
    xfer(lat, 1'b1, 2'd1, 1'b0, 32'h5, 32'h0000FFFF, rd, er, lt);
    if (er !== 1'b1 || rd !== 32'd0) begin $display("FAIL err_half_misalign lat=%0d got e=%b d=%h exp 1/0", lat, er, rd); n_fail++; end
    n_chk++;
    xfer(lat, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, er, lt);
    if (er !== 1'b0 || rd !== 32'h5A5A5A5A) begin $display("FAIL err_half_nowrite lat=%0d got e=%b d=%h exp 0/5a5a5a5a", lat, er, rd); n_fail++; end
    n_chk++;
    xfer(lat, 1'b1, 2'd3, 1'b0, 32'h0, 32'h0, rd, er, lt);
    if (er !== 1'b1) begin $display("FAIL err_size_store lat=%0d got e=%b exp 1", lat, er); n_fail++; end
    n_chk++;
    xfer(lat, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, rd, er, lt);
    if (er !== 1'b1 || rd !== 32'd0) begin $display("FAIL err_size_load lat=%0d got e=%b d=%h exp 1/0", lat, er, rd); n_fail++; end
    n_chk++;
    xfer(lat, 1'b1, 2'd2, 1'b0, 32'h1000, 32'h0, rd, er, lt);
    if (er !== 1'b1) begin $display("FAIL err_range_store lat=%0d got e=%b exp 1", lat, er); n_fail++; end
    n_chk++;
    xfer(lat, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er, lt);
    if (er !== 1'b0 || rd !== 32'hA5A5A5A5) begin $display("FAIL err_nowrite lat=%0d got e=%b d=%h exp 0/a5a5a5a5", lat, er, rd); n_fail++; end
    n_chk++;
    xfer(lat, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, rd, er, lt);
    if (er !== 1'b1 || rd !== 32'd0) begin $display("FAIL err_range_load lat=%0d got e=%b d=%h exp 1/0", lat, er, rd); n_fail++; end
    n_chk++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int lt, n;
    logic [4:0] we_pat;
    for (int i = 0; i < 8; i++) xfer(1, 1'b1, 2'd2, 1'b0, 32'h40 + 4 * i, 32'h10000000 + i * 32'h111, rd, er, lt);
    @(negedge clka);
    t_we = 1'b0; t_sz = 2'd2; t_sg = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        if (b1.rsp_valid !== 1'b1 || b1.rsp_rdata !== 32'h10000000 + (k - 1) * 32'h111 || b1.req_ready !== 1'b1) begin
          $display("FAIL b2b_l1 k=%0d got v=%b d=%h r=%b exp 1/%h/1", k, b1.rsp_valid, b1.rsp_rdata, b1.req_ready,
                   32'h10000000 + (k - 1) * 32'h111); n_fail++; end
        n_chk++;
      end
      if (k < 8) begin t_a = 32'h40 + 4 * k; v1 = 1'b1; end else v1 = 1'b0;
      @(negedge clka);
    end
    if (b1.rsp_valid !== 1'b0) begin $display("FAIL b2b_l1_end got v=%b exp 0", b1.rsp_valid); n_fail++; end
    n_chk++;
    we_pat = 5'b01001;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (!b2.req_ready && n < 4) begin @(negedge clka); n++; end
      t_we = we_pat[j]; t_a = 32'h80 + 4 * j; t_wd = 32'hCAFE0000 + j;
      v2 = 1'b1;
      @(posedge clka);
      #1 v2 = 1'b0;
      @(negedge clka);
      if (b2.req_ready !== we_pat[j]) begin
        $display("FAIL b2b_l2_ready j=%0d got %b exp %b", j, b2.req_ready, we_pat[j]); n_fail++; end
      n_chk++;
    end
    repeat (4) @(negedge clka);
    xfer(2, 1'b0, 2'd2, 1'b0, 32'h8C, 32'h0, rd, er, lt);
    if (rd !== 32'hCAFE0003) begin $display("FAIL b2b_l2_store got %h exp cafe0003", rd); n_fail++; end
    n_chk++;
  endtask

  task automatic test_raw(input int lat);
    logic [31:0] rd; logic er; int lt;
    xfer(lat, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11111111, rd, er, lt);
    @(negedge clka);
    t_we = 1'b1; t_sz = 2'd2; t_a = 32'h20; t_wd = 32'h600DF00D + lat;
    set_v(lat, 1'b1);
    @(posedge clka);
    #1 t_we = 1'b0;
    @(posedge clka);
    #1 set_v(lat, 1'b0);
    repeat (lat) @(negedge clka);
    if (rv(lat) !== 1'b1 || rrd(lat) !== 32'h600DF00D + lat) begin
      $display("FAIL raw lat=%0d got v=%b d=%h exp 1/%h", lat, rv(lat), rrd(lat), 32'h600DF00D + lat); n_fail++; end
    n_chk++;
    repeat (3) @(negedge clka);
  endtask

  initial begin
    repeat (3) @(negedge clka);
    test_reset;
    test_word(1);
    test_word(2);
    test_byte(1);
    test_byte(2);
    test_errors(1);
    test_errors(2);
    test_back_to_back;
    test_raw(1);
    test_raw(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
